// File: rtl/vgafetch_pkg.sv
// ============================================================================
// vgafetch_pkg : shared state encoding and widths for the VGA frame fetcher.
// Revision 1.0
// ============================================================================
`default_nettype none

package vgafetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_BURST = ST_BURST,
    S_DRAIN = ST_DRAIN
  } state_t;

  // Line geometry width, common with the VGA timing generator.
  localparam int GEOM_W      = 12;
  localparam int LGBURST_DEF = 3;
  localparam int BLEN_W      = LGBURST_DEF + 1;

  function automatic int blen_width(input int lgburst);
    return lgburst + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vgafetch_ctrl.sv
// ============================================================================
// vgafetch_ctrl : walks a frame buffer and streams Wishbone read bursts into
// the pixel FIFO.  Revision 1.0
// ============================================================================
`default_nettype none

module vgafetch_ctrl
  import vgafetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LGBURST        = LGBURST_DEF,
  parameter int LGFIFO         = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic                      i_frame_start,
  input  logic [ADDRESS_WIDTH-1:0]  i_base_addr,
  input  logic [ADDRESS_WIDTH-1:0]  i_line_stride,
  input  logic [11:0]               i_line_words,
  input  logic [11:0]               i_nlines,
  input  logic [LGFIFO:0]           i_fifo_fill,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic [ADDRESS_WIDTH-1:0]  o_wb_addr,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_err,
  input  logic [BUS_DATA_WIDTH-1:0] i_wb_data,
  output logic                      o_fifo_wr,
  output logic [BUS_DATA_WIDTH-1:0] o_fifo_data,
  output logic                      o_fifo_eol,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int AW   = ADDRESS_WIDTH;
  localparam int BL_W = blen_width(LGBURST);
  localparam int FW   = LGFIFO + 1;

  state_t            state, state_nx;
  logic [AW-1:0]     addr, line_addr, stride;
  logic [GEOM_W-1:0] line_words, words_left, lines_left, ack_cnt;
  logic [BL_W-1:0]   req_left, pending, len;
  logic [FW:0]       space;
  logic              discard, err;
  logic              cyc, stb, accept, ack, bus_err, drain_done, start_ok, fifo_wr;

  assign start_ok   = i_frame_start && i_en && (i_line_words != '0) && (i_nlines != '0);
  assign len        = (words_left > GEOM_W'(2**LGBURST)) ? BL_W'(2**LGBURST) : BL_W'(words_left);
  assign space      = (FW+1)'(2**LGFIFO) - (FW+1)'(i_fifo_fill);
  assign accept     = stb && !i_wb_stall;
  assign ack        = i_wb_ack && cyc;
  assign bus_err    = i_wb_err && cyc;
  assign drain_done = (state == S_DRAIN) && (pending == '0);
  assign fifo_wr    = ack && !discard;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cyc      = 1'b0;
    stb      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (start_ok)            state_nx = S_WAIT;
        else if (!i_en)          state_nx = S_IDLE;
        else if (space >= (FW+1)'(len)) state_nx = S_BURST;
      end
      S_BURST: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (i_wb_err)                               state_nx = S_IDLE;
        else if (start_ok)                          state_nx = S_DRAIN;
        else if (!i_wb_stall && req_left == BL_W'(1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        cyc = (pending != '0);
        if (cyc && i_wb_err)  state_nx = S_IDLE;
        else if (start_ok)    state_nx = S_DRAIN;
        else if (pending == '0) begin
          if (discard)                                       state_nx = S_WAIT;
          else if (!i_en)                                    state_nx = S_IDLE;
          else if (words_left == '0 && lines_left == GEOM_W'(1)) state_nx = S_IDLE;
          else                                               state_nx = S_WAIT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr       <= '0;
      line_addr  <= '0;
      stride     <= '0;
      line_words <= '0;
      words_left <= '0;
      lines_left <= '0;
      ack_cnt    <= '0;
      req_left   <= '0;
      pending    <= '0;
      discard    <= 1'b0;
      err        <= 1'b0;
    end else begin
      // A start while a burst is in flight reloads now; the stale acks are
      // then drained with discard set before the new frame issues requests.
      if (start_ok && !bus_err) begin
        addr       <= i_base_addr;
        line_addr  <= i_base_addr;
        stride     <= i_line_stride;
        line_words <= i_line_words;
        words_left <= i_line_words;
        lines_left <= i_nlines;
        ack_cnt    <= '0;
        err        <= 1'b0;
        discard    <= (state == S_BURST) || (state == S_DRAIN);
      end else begin
        if (state == S_WAIT && state_nx == S_BURST) req_left <= len;
        if (accept) begin
          addr       <= addr + AW'(1);
          req_left   <= req_left - BL_W'(1);
          words_left <= words_left - GEOM_W'(1);
        end
        if (fifo_wr) ack_cnt <= o_fifo_eol ? '0 : ack_cnt + GEOM_W'(1);
        if (drain_done) begin
          discard <= 1'b0;
          if (!discard && words_left == '0 && lines_left != GEOM_W'(1)) begin
            lines_left <= lines_left - GEOM_W'(1);
            line_addr  <= line_addr + stride;
            addr       <= line_addr + stride;
            words_left <= line_words;
          end
        end
      end
      if (bus_err) pending <= '0;
      else         pending <= pending + BL_W'(accept) - BL_W'(ack && pending != '0);
      if (bus_err) begin
        err     <= 1'b1;
        discard <= 1'b0;
      end
    end
  end

  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = stb;
  assign o_wb_addr   = addr;
  assign o_fifo_wr   = fifo_wr;
  assign o_fifo_data = i_wb_data;
  assign o_fifo_eol  = fifo_wr && (ack_cnt == line_words - GEOM_W'(1));
  assign o_busy      = (state != S_IDLE);
  assign o_err       = err;

endmodule

`default_nettype wire
